// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the JTAG TAP responder.
//   tap_state_e       - the sixteen IEEE 1149.1 TAP controller states
//   *_DEFAULT opcodes - default instruction encodings for a 5-bit IR
//   IR_CAPTURE_LSBS   - fixed pattern loaded into the IR shifter in Capture-IR
//   tap_next()        - TAP next-state function of (state, tms)
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SH_DR    = 4'd4,
        TAP_EX1_DR   = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EX2_DR   = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SH_IR    = 4'd11,
        TAP_EX1_IR   = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EX2_IR   = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE_DEFAULT = 5'h01;
    localparam logic [4:0] IR_USER_DEFAULT   = 5'h11;
    localparam logic [4:0] IR_BYPASS_DEFAULT = 5'h1F;

    // 1149.1 mandates the two IR LSBs capture as 2'b01; upper bits capture 0.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TAP_TLR:      nxt = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   nxt = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: nxt = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   nxt = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   nxt = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: nxt = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR : TAP_RTI;
            default:      nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: brings the asynchronous JTAG pins into the clock domain.
//   clock, reset_n      - system clock, synchronous active-low reset
//   tck/tms/tdi/trst_n  - raw pin inputs
//   tck_rise, tck_fall  - registered single-cycle strobes on TCK edges
//   tms_sync, tdi_sync  - TMS/TDI delayed to line up with the strobes
//   trst_n_sync         - synchronized TRSTn (two flops, not delayed further)
module jtag_sync_edge
    import jtag_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    input  logic trst_n,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_sync,
    output logic tdi_sync,
    output logic trst_n_sync
);

    // Bit order in the synchronizer vectors: {trst_n, tdi, tms, tck}.
    logic [3:0] meta_r;
    logic [3:0] sync_r;
    logic       tck_d_r;
    logic       rise_r;
    logic       fall_r;
    logic       tms_r;
    logic       tdi_r;

    // Two-flop synchronizer followed by the TCK edge flop and strobe registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta_r  <= 4'b0000;
            sync_r  <= 4'b0000;
            tck_d_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            tms_r   <= 1'b0;
            tdi_r   <= 1'b0;
        end else begin
            meta_r  <= {trst_n, tdi, tms, tck};
            sync_r  <= meta_r;
            tck_d_r <= sync_r[0];
            rise_r  <= sync_r[0] & ~tck_d_r;
            fall_r  <= ~sync_r[0] & tck_d_r;
            // Delayed with the strobes so the TAP sees TMS/TDI as of the edge.
            tms_r   <= sync_r[1];
            tdi_r   <= sync_r[2];
        end
    end

    assign tck_rise    = rise_r;
    assign tck_fall    = fall_r;
    assign tms_sync    = tms_r;
    assign tdi_sync    = tdi_r;
    assign trst_n_sync = sync_r[3];

endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: JTAG TAP target clocked entirely by the system clock.
//   clock, reset_n                 - system clock, synchronous active-low reset
//   jtag_TCK/TMS/TDI/TRSTn         - asynchronous pins from the JTAG driver
//   jtag_TDO_data, jtag_TDO_driven - serial output and its drive enable
//   user_capture_data              - loaded into the user DR in Capture-DR
//   user_update_data/_valid        - user DR latched in Update-DR, 1-clock pulse
//   tap_ir                         - currently active instruction
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int                     IR_WIDTH      = 5,
    parameter logic [31:0]            IDCODE_VALUE  = 32'h0000_0001,
    parameter int                     USER_DR_WIDTH = 41,
    parameter logic [IR_WIDTH-1:0]    IR_IDCODE     = IR_IDCODE_DEFAULT,
    parameter logic [IR_WIDTH-1:0]    IR_USER       = IR_USER_DEFAULT,
    parameter logic [IR_WIDTH-1:0]    IR_BYPASS     = IR_BYPASS_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     jtag_TCK,
    input  logic                     jtag_TMS,
    input  logic                     jtag_TDI,
    input  logic                     jtag_TRSTn,
    output logic                     jtag_TDO_data,
    output logic                     jtag_TDO_driven,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data,
    output logic [USER_DR_WIDTH-1:0] user_update_data,
    output logic                     user_update_valid,
    output logic [IR_WIDTH-1:0]      tap_ir
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE_LSBS};

    logic tck_rise_s, tck_fall_s, tms_s, tdi_s, trst_n_s;

    jtag_sync_edge u_sync (
        .clock       (clock),
        .reset_n     (reset_n),
        .tck         (jtag_TCK),
        .tms         (jtag_TMS),
        .tdi         (jtag_TDI),
        .trst_n      (jtag_TRSTn),
        .tck_rise    (tck_rise_s),
        .tck_fall    (tck_fall_s),
        .tms_sync    (tms_s),
        .tdi_sync    (tdi_s),
        .trst_n_sync (trst_n_s)
    );

    tap_state_e                 state_r, next_state_s;
    logic [IR_WIDTH-1:0]        ir_shift_r, tap_ir_r;
    logic [31:0]                idcode_sr_r;
    logic [USER_DR_WIDTH-1:0]   user_sr_r, user_update_data_r;
    logic                       bypass_r, user_update_valid_r;
    logic                       tdo_data_r, tdo_driven_r;
    logic                       in_shift_ir_s, in_shift_dr_s;
    logic                       sel_idcode_s, sel_user_s, dr_lsb_s;

    // TAP state register; TRSTn forces Test-Logic-Reset on every clock.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= TAP_TLR;
        end else if (!trst_n_s) begin
            state_r <= TAP_TLR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: the TAP only moves on a TCK rising strobe.
    always_comb begin
        next_state_s = state_r;
        if (tck_rise_s) begin
            next_state_s = tap_next(state_r, tms_s);
        end else begin
            next_state_s = state_r;
        end
    end

    // Output decode: shift-state flags and data register selection.
    always_comb begin
        in_shift_ir_s = (state_r == TAP_SH_IR);
        in_shift_dr_s = (state_r == TAP_SH_DR);
        sel_idcode_s  = 1'b0;
        sel_user_s    = 1'b0;
        dr_lsb_s      = bypass_r;
        case (tap_ir_r)
            IR_IDCODE: begin
                sel_idcode_s = 1'b1;
                dr_lsb_s     = idcode_sr_r[0];
            end
            IR_USER: begin
                sel_user_s = 1'b1;
                dr_lsb_s   = user_sr_r[0];
            end
            IR_BYPASS: dr_lsb_s = bypass_r;
            // Unrecognised opcodes fall back to the 1-bit bypass register.
            default:   dr_lsb_s = bypass_r;
        endcase
    end

    // Instruction register: capture/shift/update on TCK rise, IDCODE in TLR.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ir_shift_r <= {IR_WIDTH{1'b0}};
            tap_ir_r   <= IR_IDCODE;
        end else if (!trst_n_s || state_r == TAP_TLR) begin
            tap_ir_r   <= IR_IDCODE;
        end else if (tck_rise_s) begin
            case (state_r)
                TAP_CAP_IR: ir_shift_r <= IR_CAPTURE;
                TAP_SH_IR:  ir_shift_r <= {tdi_s, ir_shift_r[IR_WIDTH-1:1]};
                TAP_UPD_IR: tap_ir_r   <= ir_shift_r;
                default:    ir_shift_r <= ir_shift_r;
            endcase
        end else begin
            ir_shift_r <= ir_shift_r;
        end
    end

    // Data registers: the selected one captures or shifts on TCK rise.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idcode_sr_r <= 32'h0000_0000;
            user_sr_r   <= {USER_DR_WIDTH{1'b0}};
            bypass_r    <= 1'b0;
        end else if (tck_rise_s && trst_n_s) begin
            case (state_r)
                TAP_CAP_DR: begin
                    if (sel_idcode_s)    idcode_sr_r <= IDCODE_VALUE;
                    else if (sel_user_s) user_sr_r   <= user_capture_data;
                    else                 bypass_r    <= 1'b0;
                end
                TAP_SH_DR: begin
                    if (sel_idcode_s)    idcode_sr_r <= {tdi_s, idcode_sr_r[31:1]};
                    else if (sel_user_s) user_sr_r   <= {tdi_s, user_sr_r[USER_DR_WIDTH-1:1]};
                    else                 bypass_r    <= tdi_s;
                end
                default: bypass_r <= bypass_r;
            endcase
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // User update: latch the user shifter and pulse valid for one clock.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            user_update_data_r  <= {USER_DR_WIDTH{1'b0}};
            user_update_valid_r <= 1'b0;
        end else if (trst_n_s && tck_rise_s && state_r == TAP_UPD_DR && sel_user_s) begin
            user_update_data_r  <= user_sr_r;
            user_update_valid_r <= 1'b1;
        end else begin
            user_update_valid_r <= 1'b0;
        end
    end

    // TDO: launched on TCK fall so the driver samples it on the next rise.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tdo_data_r   <= 1'b0;
            tdo_driven_r <= 1'b0;
        end else if (!trst_n_s) begin
            tdo_driven_r <= 1'b0;
        end else if (tck_fall_s) begin
            tdo_driven_r <= in_shift_ir_s | in_shift_dr_s;
            if (in_shift_ir_s)      tdo_data_r <= ir_shift_r[0];
            else if (in_shift_dr_s) tdo_data_r <= dr_lsb_s;
            else                    tdo_data_r <= tdo_data_r;
        end else begin
            tdo_data_r <= tdo_data_r;
        end
    end

    assign jtag_TDO_data     = tdo_data_r;
    assign jtag_TDO_driven   = tdo_driven_r;
    assign user_update_data  = user_update_data_r;
    assign user_update_valid = user_update_valid_r;
    assign tap_ir            = tap_ir_r;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: drives TCK/TMS/TDI like the JTAG driver and checks
// TDO bits against a queue of expected bits plus IR/update side effects.
module tb_jtag_tap_responder;
    import jtag_pkg::*;

    localparam int UW = 41;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic          tdo_data, tdo_driven, upd_valid;
    logic [UW-1:0] cap_data = '0;
    logic [UW-1:0] upd_data;
    logic [4:0]    ir;

    int n_cmp = 0, n_err = 0;
    int pulse_cnt = 0, run_len = 0, max_run = 0;
    bit done = 1'b0;
    bit exp_q[$];

    jtag_tap_responder dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .jtag_TCK          (tck),
        .jtag_TMS          (tms),
        .jtag_TDI          (tdi),
        .jtag_TRSTn        (trst_n),
        .jtag_TDO_data     (tdo_data),
        .jtag_TDO_driven   (tdo_driven),
        .user_capture_data (cap_data),
        .user_update_data  (upd_data),
        .user_update_valid (upd_valid),
        .tap_ir            (ir)
    );

    always #5 clock = ~clock;

    // Count update pulses and track the longest run of consecutive valid clocks.
    always @(posedge clock) begin
        if (upd_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            run_len   <= run_len + 1;
        end else begin
            run_len <= 0;
        end
        if (run_len > max_run) max_run <= run_len;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One TCK period: TDO is sampled just before the rise, as a driver would.
    task automatic jtag_clk(input logic t_ms, input logic t_di, output logic t_do, output logic t_drv);
        tms = t_ms;
        tdi = t_di;
        clocks(4);
        t_do  = tdo_data;
        t_drv = tdo_driven;
        tck = 1'b1;
        clocks(6);
        tck = 1'b0;
        clocks(6);
    endtask

    task automatic tms_seq(input int n, input logic [7:0] bits);
        logic d, v;
        for (int i = 0; i < n; i++) jtag_clk(bits[i], 1'b0, d, v);
    endtask

    // Shift n bits LSB-first, leaving Shift on the last bit (TMS=1).
    task automatic shift_bits(input string tag, input int n, input logic [63:0] din, input logic [63:0] exp);
        logic d, v;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp[i]);
            jtag_clk(i == n - 1, din[i], d, v);
            check_val(tag, {63'd0, d}, {63'd0, exp_q.pop_front()});
            check_val({tag, "_driven"}, {63'd0, v}, 64'd1);
        end
    endtask

    // From RTI: load an IR value and return to RTI.
    task automatic load_ir(input logic [4:0] val);
        tms_seq(4, 8'b0000_0011);              // SelDR, SelIR, CapIR, ShIR
        shift_bits("ir_capture", 5, {59'd0, val}, 64'h01);
        tms_seq(2, 8'b0000_0001);              // UpdIR, RTI
    endtask

    initial begin
        int p0;
        clocks(2);
        reset_n = 1'b1;
        clocks(3);
        check_val("rst_tap_ir", ir, 64'h01);
        check_val("rst_tdo_driven", tdo_driven, 64'd0);
        check_val("rst_tdo_data", tdo_data, 64'd0);
        check_val("rst_upd_data", upd_data, 64'd0);
        check_val("rst_upd_valid", upd_valid, 64'd0);
        check_val("rst_state", dut.state_r, TAP_TLR);

        // IDCODE read straight out of reset.
        tms_seq(4, 8'b0000_0010);              // RTI, SelDR, CapDR, ShDR
        shift_bits("idcode", 32, 64'd0, 64'h0000_0001);
        tms_seq(2, 8'b0000_0001);
        check_val("idcode_exit_driven", tdo_driven, 64'd0);

        // BYPASS: output is the input delayed by one bit.
        load_ir(5'h1F);
        check_val("ir_bypass", ir, 64'h1F);
        tms_seq(3, 8'b0000_0001);              // SelDR, CapDR, ShDR
        shift_bits("bypass", 4, 64'b1101, 64'b1010);
        tms_seq(2, 8'b0000_0001);

        // USER DR: capture readback and update pulse.
        cap_data = 41'h1_2345_6789A;
        load_ir(5'h11);
        check_val("ir_user", ir, 64'h11);
        p0 = pulse_cnt;
        tms_seq(3, 8'b0000_0001);
        shift_bits("user_dr", UW, 64'h0_AAAA_5555, 64'h1_2345_6789A);
        tms_seq(2, 8'b0000_0001);
        clocks(2);
        check_val("user_upd_data", upd_data, 64'h0_AAAA_5555);
        check_val("user_upd_pulses", pulse_cnt - p0, 64'd1);
        check_val("user_upd_width", max_run, 64'd1);

        // TRSTn in the middle of a user DR shift.
        tms_seq(3, 8'b0000_0001);
        tms_seq(5, 8'b0000_0000);              // stay in ShDR
        check_val("pre_trst_driven", tdo_driven, 64'd1);
        p0 = pulse_cnt;
        trst_n = 1'b0;
        clocks(3);
        check_val("trst_driven", tdo_driven, 64'd0);
        check_val("trst_state", dut.state_r, TAP_TLR);
        check_val("trst_tap_ir", ir, 64'h01);
        clocks(1);
        trst_n = 1'b1;
        clocks(4);
        check_val("trst_no_pulse", pulse_cnt - p0, 64'd0);
        check_val("trst_upd_hold", upd_data, 64'h0_AAAA_5555);

        // Five TMS=1 rises from Pause-IR reach TLR.
        tms_seq(1, 8'b0000_0000);              // RTI
        load_ir(5'h1F);
        check_val("ir_bypass2", ir, 64'h1F);
        tms_seq(5, 8'b0000_1011);              // SelDR, SelIR, CapIR, Ex1IR, PauseIR
        check_val("pause_ir_state", dut.state_r, TAP_PAUSE_IR);
        tms_seq(5, 8'b0001_1111);
        clocks(2);
        check_val("tms5_state", dut.state_r, TAP_TLR);
        check_val("tms5_tap_ir", ir, 64'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        done = 1'b1;
        $finish;
    end

    initial begin
        #1000000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule

// File: doc/jtag_tap_responder.md
# jtag_tap_responder

Synthesizable JTAG TAP responder; the target end of the simulation JTAG driver. It oversamples the TCK/TMS/TDI/TRSTn pins in the system clock domain and runs the IEEE 1149.1 16-state TAP controller. It implements IR, IDCODE, BYPASS and one parameterizable user data register (debug-transport register path), and returns jtag_TDO_data / jtag_TDO_driven to the driver.

## Interface
- IR_WIDTH, 5, instruction register width
- IDCODE_VALUE, 32'h0000_0001, value captured by IDCODE; bit 0 must be 1
- USER_DR_WIDTH, 41, width of the user data register
- IR_IDCODE, 5'h01, IDCODE opcode; IR_USER, 5'h11, user DR opcode; IR_BYPASS, 5'h1F, bypass opcode
- clock  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn  in  1 each  asynchronous pin inputs; TRSTn active-low
- jtag_TDO_data  out  1  serial output
- jtag_TDO_driven  out  1  high while in Shift-IR or Shift-DR
- user_capture_data  in  USER_DR_WIDTH  value loaded in Capture-DR when IR=IR_USER
- user_update_data  out  USER_DR_WIDTH  shift register contents latched in Update-DR when IR=IR_USER
- user_update_valid  out  1  one-clock pulse coincident with user_update_data change
- tap_ir  out  IR_WIDTH  current active instruction

## Operation
- Pins pass through a 2-flop synchronizer; a third flop on TCK gives tck_rise and tck_fall single-cycle strobes.
- Synchronized TRSTn low: state forced to Test-Logic-Reset, IR=IR_IDCODE, TDO_driven=0, every clock, overriding all else.
- On tck_rise: TAP state advances on synchronized TMS (standard 16 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR). Register action follows the state being left (current state at the rise):
  - CapIR: ir_shift <= {0..,1}, LSBs 2'b01.
  - ShIR: ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
  - UpdIR: tap_ir <= ir_shift.
  - CapDR: selected DR loads (IDCODE_VALUE / user_capture_data / bypass=0).
  - ShDR: selected DR shifts right, TDI into MSB.
  - UpdDR with IR_USER: user_update_data <= user shift reg, user_update_valid pulse.
- Any opcode other than IDCODE/USER selects BYPASS (1 bit).
- Five consecutive tck_rise with TMS=1 reach TLR from any state; TLR sets tap_ir=IR_IDCODE.
- On tck_fall: jtag_TDO_data <= LSB of active shift register (IR in ShIR, selected DR in ShDR); jtag_TDO_driven <= (state is ShIR or ShDR); otherwise TDO_data holds.
- Reset values: TAP state TLR, tap_ir=IR_IDCODE, jtag_TDO_data=0, jtag_TDO_driven=0, user_update_data=0, user_update_valid=0, shift registers 0.

## Timing
- Pin edge to strobe: 3 clocks (2 sync + edge flop); state/registers update on the next clock edge.
- TDO reflects tck_fall one clock after the strobe (4 clocks after pin fall).
- Requirement on driver: TCK high and low each ≥ 4 clock cycles; TMS/TDI stable ≥ 3 clocks before TCK rise. Faster TCK is unsupported (edges may be lost).
- user_update_valid is exactly 1 clock wide, one per UpdDR traversal.
- reset_n low and TRSTn low together: reset_n values apply. reset_n mid-shift: shift contents lost, state TLR, no update pulse.
- Simultaneous tck_rise and tck_fall cannot occur (single edge flop).

## Structure
- Package jtag_pkg: tap_state_e enum (16 states), default opcode localparams, IR capture constant.
- Sub-module jtag_sync_edge: 2-flop synchronizer for the four pins plus TCK rise/fall strobes.
- TAP next-state is a combinational function in jtag_pkg (tap_next(state, tms)).

## Test plan
- reset_n low 2 clocks then release -> TDO_driven=0, tap_ir=5'h01, state TLR.
- TMS 0,1,0,0 then shift 32 bits TDI=0 -> TDO stream LSB-first equals IDCODE_VALUE 32'h0000_0001.
- Load IR=5'h1F via ShIR, shift DR pattern 1,0,1,1 -> TDO pattern delayed by one bit (0,1,0,1).
- IR=5'h11, user_capture_data=41'h1_2345_6789A, shift 41 bits of 41'h0_AAAA_5555 -> TDO returns capture value; after UpdDR user_update_data=41'h0_AAAA_5555, user_update_valid one clock.
- Mid-ShDR assert jtag_TRSTn=0 for 4 clocks -> state TLR, TDO_driven=0 within 3 clocks, no update pulse.
- Five TMS=1 rises from PauseIR -> TLR, tap_ir=5'h01.
